mmem_line_responder: RTL and testbench

//  Main-memory-side responder for the cache controller's line-fill interface.
//  - Accepts whole-line read/write requests (mmem_r / mmem_w).
//  - Models fixed access latency, then moves the line one word per cycle
//    to/from a word-wide backing array.
//  - Signals completion with a one-cycle mmem_status pulse.

---
 rtl/mmem_line_responder_if.sv | 22 ++
 rtl/mmem_line_responder.sv | 118 +++++++++++
 tb/tb_mmem_line_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmem_line_responder_if.sv
// Line-fill bus between the L1 cache controller (master) and main-memory responder (slave).
interface mmem_line_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              mmem_r;
  logic              mmem_w;
  logic [ADDR_W-1:0] mmem_addr;
  logic [LINE_W-1:0] mmem_wdata;
  logic [LINE_W-1:0] mmem_rdata;
  logic              mmem_status;

  modport master (
    output mmem_r, mmem_w, mmem_addr, mmem_wdata,
    input  mmem_rdata, mmem_status
  );

  modport slave (
    input  mmem_r, mmem_w, mmem_addr, mmem_wdata,
    output mmem_rdata, mmem_status
  );
endinterface

// File: rtl/mmem_line_responder.sv
// Main-memory line responder: fixed access latency, then one word per cycle
// between a line buffer and a word-wide backing array, with a done pulse.
module mmem_line_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mmem_line_responder_if.slave bus
);

  localparam int unsigned WORDS  = LINE_W / WORD_W;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned MEM_N  = DEPTH * WORDS;
  localparam int unsigned MEM_AW = $clog2(MEM_N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_nxt;
  logic              accept;
  logic              last;
  logic              op_w_q;
  logic [IDX_W-1:0]  line_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDX_W-1:0] widx_q;
  logic [LINE_W-1:0] wbuf_q;
  logic [LINE_W-1:0] rbuf_q;
  logic [LINE_W-1:0] rbuf_nxt;
  logic [LINE_W-1:0] rdata_q;
  logic              status_q;
  logic [MEM_AW-1:0] maddr;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr;

  logic [WORD_W-1:0] mem [MEM_N];

  // Offset and upper address bits are don't-care; only the line index matters.
  assign unused_addr = ^bus.mmem_addr;

  assign maddr    = MEM_AW'(line_q) * MEM_AW'(WORDS) + MEM_AW'(widx_q);
  assign rd_word  = mem[maddr];
  assign last     = (widx_q == WIDX_W'(WORDS - 1));
  // Words shift in from the top so word 0 ends at the LSB after WORDS steps.
  assign rbuf_nxt = (rbuf_q >> WORD_W) | (LINE_W'(rd_word) << (LINE_W - WORD_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mmem_r || bus.mmem_w) begin
          accept    = 1'b1;
          state_nxt = (LATENCY == 0) ? XFER : WAIT;
        end
      end
      WAIT:    if (cnt_q == '0) state_nxt = XFER;
      XFER:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency count, word sequencing and line assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_w_q   <= 1'b0;
      line_q   <= '0;
      cnt_q    <= '0;
      widx_q   <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      status_q <= 1'b0;
    end else begin
      status_q <= (state_nxt == DONE);
      if (accept) begin
        op_w_q <= bus.mmem_w;
        line_q <= bus.mmem_addr[OFF_W +: IDX_W];
        cnt_q  <= CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
        widx_q <= '0;
        if (bus.mmem_w) wbuf_q <= bus.mmem_wdata;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == XFER) begin
        widx_q <= widx_q + WIDX_W'(1);
        if (op_w_q) begin
          wbuf_q <= wbuf_q >> WORD_W;
        end else begin
          rbuf_q <= rbuf_nxt;
          if (last) rdata_q <= rbuf_nxt;
        end
      end
    end
  end

  // Backing array has no reset; aborted writes leave their words in place.
  always_ff @(posedge clk) begin
    if (state_q == XFER && op_w_q) mem[maddr] <= wbuf_q[WORD_W-1:0];
  end

  assign bus.mmem_rdata  = rdata_q;
  assign bus.mmem_status = status_q;

endmodule

// File: tb/tb_mmem_line_responder.sv
// Randomized self-checking bench for mmem_line_responder (LATENCY=4 and LATENCY=0 instances).
module tb_mmem_line_responder;
  localparam int unsigned DEPTH = 256;
  typedef logic [255:0] line_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mmem_line_responder_if if4 ();
  mmem_line_responder_if if0 ();

  mmem_line_responder #(.LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  mmem_line_responder #(.LATENCY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  logic        r_d = 1'b0, w_d = 1'b0, sel0 = 1'b0;
  logic [31:0] addr_d = '0;
  line_t       wdata_d = '0;

  assign if4.mmem_r     = r_d & ~sel0;
  assign if4.mmem_w     = w_d & ~sel0;
  assign if0.mmem_r     = r_d & sel0;
  assign if0.mmem_w     = w_d & sel0;
  assign if4.mmem_addr  = addr_d;
  assign if0.mmem_addr  = addr_d;
  assign if4.mmem_wdata = wdata_d;
  assign if0.mmem_wdata = wdata_d;

  wire   status_s = sel0 ? if0.mmem_status : if4.mmem_status;
  line_t rdata_s;
  assign rdata_s = sel0 ? if0.mmem_rdata : if4.mmem_rdata;

  int vectors = 0;
  int errors  = 0;

  // Reference model: whole lines per index, plus the last completed read line.
  line_t mem_m   [2][DEPTH];
  bit    valid_m [2][DEPTH];
  line_t last_rd [2];

  function automatic int lidx(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic line_t model_op(input bit s0, input bit r, input bit w,
                                     input logic [31:0] a, input line_t d);
    int l = lidx(a);
    if (w) begin
      mem_m[s0][l]   = d;
      valid_m[s0][l] = 1'b1;
    end else if (r) begin
      last_rd[s0] = mem_m[s0][l];
    end
    return last_rd[s0];
  endfunction

  function automatic line_t rand_line();
    line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete transaction; inputs are scrambled after accept to prove they are ignored.
  task automatic txn(input bit s0, input bit r, input bit w, input logic [31:0] a,
                     input line_t d, output int lat, output line_t rd, output int extra);
    int c0;
    @(posedge clk); #1;
    sel0 = s0; c0 = cyc;
    r_d = r; w_d = w; addr_d = a; wdata_d = d;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin addr_d = $urandom; wdata_d = rand_line(); end
      if (status_s) begin lat = cyc - c0; break; end
    end
    rd = rdata_s;
    r_d = 1'b0; w_d = 1'b0;
    extra = 0;
    repeat (3) begin @(posedge clk); #1; if (status_s) extra++; end
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (if4.mmem_status !== 1'b0) begin errors++; $display("FAIL reset_status4: got %b want 0", if4.mmem_status); end
    vectors++; if (if4.mmem_rdata !== '0) begin errors++; $display("FAIL reset_rdata4: got %h want 0", if4.mmem_rdata); end
    vectors++; if (if0.mmem_rdata !== '0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", if0.mmem_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    line_t d, exp, rd; int lat, extra;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    exp = model_op(1'b0, 1'b0, 1'b1, 32'h40, d);
    txn(1'b0, 1'b0, 1'b1, 32'h40, d, lat, rd, extra);
    vectors++; if (lat !== 13) begin errors++; $display("FAIL wr_latency: got %0d want 13", lat); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", rd, exp); end
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h40, '0);
    txn(1'b0, 1'b1, 1'b0, 32'h40, '0, lat, rd, extra);
    vectors++; if (lat !== 13) begin errors++; $display("FAIL rd_latency: got %0d want 13", lat); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL rd_data: got %h want %h", rd, exp); end
    vectors++; if (extra !== 0) begin errors++; $display("FAIL rd_single_pulse: got %0d extra want 0", extra); end
  endtask

  task automatic test_latency0();
    line_t d, exp, rd; int lat, extra;
    d = rand_line();
    exp = model_op(1'b1, 1'b0, 1'b1, 32'h40, d);
    txn(1'b1, 1'b0, 1'b1, 32'h40, d, lat, rd, extra);
    vectors++; if (lat !== 9) begin errors++; $display("FAIL lat0_wr_latency: got %0d want 9", lat); end
    exp = model_op(1'b1, 1'b1, 1'b0, 32'h40, '0);
    txn(1'b1, 1'b1, 1'b0, 32'h40, '0, lat, rd, extra);
    vectors++; if (lat !== 9) begin errors++; $display("FAIL lat0_rd_latency: got %0d want 9", lat); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL lat0_rd_data: got %h want %h", rd, exp); end
    vectors++; if (extra !== 0) begin errors++; $display("FAIL lat0_single_pulse: got %0d extra want 0", extra); end
  endtask

  task automatic test_wrap();
    line_t d, exp, rd; int lat, extra;
    d = rand_line();
    exp = model_op(1'b0, 1'b0, 1'b1, 32'h2000, d);
    txn(1'b0, 1'b0, 1'b1, 32'h2000, d, lat, rd, extra);
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h1F, '0);
    txn(1'b0, 1'b1, 1'b0, 32'h1F, '0, lat, rd, extra);
    vectors++; if (rd !== exp) begin errors++; $display("FAIL wrap_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_rw_both();
    line_t d, exp, rd; int lat, extra;
    d = rand_line();
    exp = model_op(1'b0, 1'b1, 1'b1, 32'h80, d);
    txn(1'b0, 1'b1, 1'b1, 32'h80, d, lat, rd, extra);
    vectors++; if (lat !== 13) begin errors++; $display("FAIL rw_latency: got %0d want 13", lat); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL rw_rdata_hold: got %h want %h", rd, exp); end
    vectors++; if (extra !== 0) begin errors++; $display("FAIL rw_single_pulse: got %0d extra want 0", extra); end
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h80, '0);
    txn(1'b0, 1'b1, 1'b0, 32'h80, '0, lat, rd, extra);
    vectors++; if (rd !== exp) begin errors++; $display("FAIL rw_readback: got %h want %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    line_t exp; int c0, t1, t2, extra;
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h40, '0);
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h40, '0);
    @(posedge clk); #1;
    sel0 = 1'b0; c0 = cyc; r_d = 1'b1; w_d = 1'b0; addr_d = 32'h40;
    t1 = -1; t2 = -1; extra = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (status_s) begin t1 = cyc - c0; break; end
    end
    @(posedge clk); #1;
    if (status_s) extra++;
    @(posedge clk); #1;
    r_d = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (status_s) begin t2 = cyc - c0; break; end
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; if (status_s) extra++; end
    vectors++; if (t1 !== 13) begin errors++; $display("FAIL b2b_first: got %0d want 13", t1); end
    vectors++; if (t2 !== 27) begin errors++; $display("FAIL b2b_second: got %0d want 27", t2); end
    vectors++; if (extra !== 0) begin errors++; $display("FAIL b2b_no_double: got %0d extra want 0", extra); end
    vectors++; if (if4.mmem_rdata !== exp) begin errors++; $display("FAIL b2b_data: got %h want %h", if4.mmem_rdata, exp); end
  endtask

  task automatic test_random();
    line_t d, exp, rd; int lat, extra, op, l;
    bit s0, r, w;
    logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      s0 = 1'($urandom % 2);
      op = int'($urandom % 3);
      l  = int'($urandom % 8);
      a  = ($urandom & 32'hFFFF_E000) | (32'(l) << 5) | ($urandom % 32);
      r  = (op != 1); w = (op != 0);
      if (!w && !valid_m[s0][l]) begin r = 1'b0; w = 1'b1; end
      d = rand_line();
      exp = model_op(s0, r, w, a, d);
      txn(s0, r, w, a, d, lat, rd, extra);
      vectors++; if (lat !== (s0 ? 9 : 13)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, s0 ? 9 : 13); end
      vectors++; if (rd !== exp) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, exp); end
      vectors++; if (extra !== 0) begin errors++; $display("FAIL rand_pulse[%0d]: got %0d extra want 0", k, extra); end
    end
  endtask

  task automatic test_reset_mid();
    line_t exp, rd; int lat, extra;
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h40, '0);
    txn(1'b0, 1'b1, 1'b0, 32'h40, '0, lat, rd, extra);
    @(posedge clk); #1;
    sel0 = 1'b0; r_d = 1'b1; w_d = 1'b0; addr_d = 32'h2000;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (if4.mmem_status !== 1'b0) begin errors++; $display("FAIL midrst_status: got %b want 0", if4.mmem_status); end
    vectors++; if (if4.mmem_rdata !== '0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", if4.mmem_rdata); end
    r_d = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp = model_op(1'b0, 1'b1, 1'b0, 32'h40, '0);
    txn(1'b0, 1'b1, 1'b0, 32'h40, '0, lat, rd, extra);
    vectors++; if (lat !== 13) begin errors++; $display("FAIL postrst_latency: got %0d want 13", lat); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL postrst_data: got %h want %h", rd, exp); end
  endtask

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    test_reset();
    test_write_read();
    test_latency0();
    test_wrap();
    test_rw_both();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
